// File: rtl/result_pkg.sv
// Shared definitions for the result serializer slice.
//   DATA_W         : width of the output-neuron result word
//   DEPTH          : number of buffered result words (power of two)
//   BYTES_PER_WORD : bytes emitted per result word
//   state_e        : byte-index state machine encoding
package result_pkg;

  localparam int unsigned DATA_W         = 23;
  localparam int unsigned DEPTH          = 4;
  localparam int unsigned BYTES_PER_WORD = 3;

  typedef enum logic [1:0] {
    IDLE,
    SEND0,
    SEND1,
    SEND2
  } state_e;

endpackage

// File: rtl/result_fifo.sv
// Synchronous word FIFO with a combinational head.
//   clk_i, rst_i : clock, synchronous active-high reset (clears pointers/count)
//   wr_i         : write wr_data_i at the tail (ignored when full unless popping)
//   pop_i        : drop the head word (ignored when empty)
//   head_o       : word at the head
//   count_o      : occupancy in words
//   full_o       : count_o == DEPTH
//   empty_o      : count_o == 0
module result_fifo #(
  parameter int unsigned DATA_W = 23,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_wr;
  logic              do_pop;

  assign full_o  = (count_o == CNT_W'(DEPTH));
  assign empty_o = (count_o == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_wr   = wr_i & (~full_o | do_pop);
  assign head_o  = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({do_wr, do_pop})
        2'b10:   count_o <= count_o + CNT_W'(1);
        2'b01:   count_o <= count_o - CNT_W'(1);
        default: count_o <= count_o;
      endcase
    end
  end

endmodule

// File: rtl/result_serializer.sv
// Buffers output-neuron result words and streams each as 3 bytes, LSB first.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   en_i            : capture enable (capture_i ignored while low)
//   capture_i       : one-cycle pulse, final_i valid
//   final_i         : result word
//   byte_o          : current byte (0 while idle)
//   byte_valid_o    : byte_o valid
//   byte_ready_i    : consumer accepts byte_o
//   frame_start_o   : byte_o is byte 0 of a word
//   count_o         : FIFO occupancy in words
//   overflow_o      : sticky, set when a capture is dropped on a full FIFO
//   clear_ovf_i     : clears overflow_o (a coincident drop wins)
module result_serializer
  import result_pkg::*;
#(
  parameter int unsigned DATA_W = result_pkg::DATA_W,
  parameter int unsigned DEPTH  = result_pkg::DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     capture_i,
  input  logic [DATA_W-1:0]        final_i,
  output logic [7:0]               byte_o,
  output logic                     byte_valid_o,
  input  logic                     byte_ready_i,
  output logic                     frame_start_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  input  logic                     clear_ovf_i
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  state_e                        state;
  state_e                        state_nxt;
  logic [DATA_W-1:0]             head;
  logic [BYTES_PER_WORD*8-1:0]   padded;
  logic                          full;
  logic                          empty;
  logic                          pop;
  logic                          wr;
  logic                          drop;

  // A pop only happens in SEND2, which needs a non-empty FIFO, so a write
  // into an empty FIFO can never be popped in the same cycle.
  assign pop  = (state == SEND2) & byte_ready_i;
  assign wr   = capture_i & en_i & (~full | pop);
  assign drop = capture_i & en_i & full & ~pop;

  result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_i      (wr),
    .wr_data_i (final_i),
    .pop_i     (pop),
    .head_o    (head),
    .count_o   (count_o),
    .full_o    (full),
    .empty_o   (empty)
  );

  // Upper bits of the last byte are zero-padded.
  always_comb begin
    padded = '0;
    padded[DATA_W-1:0] = head;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    byte_valid_o  = 1'b0;
    frame_start_o = 1'b0;
    byte_o        = '0;
    case (state)
      IDLE: begin
        if (!empty) state_nxt = SEND0;
      end
      SEND0: begin
        byte_valid_o  = 1'b1;
        frame_start_o = 1'b1;
        byte_o        = padded[7:0];
        if (byte_ready_i) state_nxt = SEND1;
      end
      SEND1: begin
        byte_valid_o = 1'b1;
        byte_o       = padded[15:8];
        if (byte_ready_i) state_nxt = SEND2;
      end
      SEND2: begin
        byte_valid_o = 1'b1;
        byte_o       = padded[23:16];
        // Occupancy after this pop, counting a same-cycle write.
        if (byte_ready_i) begin
          state_nxt = ((count_o > CNT_W'(1)) || wr) ? SEND0 : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_o <= 1'b0;
    end else if (drop) begin
      overflow_o <= 1'b1;
    end else if (clear_ovf_i) begin
      overflow_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_result_serializer.sv
module tb_result_serializer;

  localparam int unsigned DW = 23;
  localparam int unsigned DP = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          en_i;
  logic          capture_i;
  logic [DW-1:0] final_i;
  logic [7:0]    byte_o;
  logic          byte_valid_o;
  logic          byte_ready_i;
  logic          frame_start_o;
  logic [2:0]    count_o;
  logic          overflow_o;
  logic          clear_ovf_i;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [8:0]  exp_q[$];

  result_serializer #(
    .DATA_W (DW),
    .DEPTH  (DP)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .en_i          (en_i),
    .capture_i     (capture_i),
    .final_i       (final_i),
    .byte_o        (byte_o),
    .byte_valid_o  (byte_valid_o),
    .byte_ready_i  (byte_ready_i),
    .frame_start_o (frame_start_o),
    .count_o       (count_o),
    .overflow_o    (overflow_o),
    .clear_ovf_i   (clear_ovf_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_word(input logic [23:0] w);
    exp_q.push_back({1'b1, w[7:0]});
    exp_q.push_back({1'b0, w[15:8]});
    exp_q.push_back({2'b00, w[22:16]});
  endtask

  task automatic capture(input logic [23:0] w);
    capture_i = 1'b1;
    final_i   = w[DW-1:0];
    tick();
    capture_i = 1'b0;
  endtask

  // Scoreboard monitor: pops an expected byte on every handshake.
  task automatic monitor;
    logic [8:0] e;
    forever begin
      @(negedge clk_i);
      if (!rst_i && byte_valid_o && byte_ready_i) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no byte", byte_o);
        end else begin
          e = exp_q.pop_front();
          check("sb_byte", 32'(byte_o), 32'(e[7:0]));
          check("sb_frame_start", 32'(frame_start_o), 32'(e[8]));
        end
      end
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick();
    tick();
  endtask

  logic [23:0] words [5];

  initial begin
    fork
      monitor();
    join_none

    rst_i = 1'b1; en_i = 1'b1; capture_i = 1'b0; final_i = '0;
    byte_ready_i = 1'b1; clear_ovf_i = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(byte_valid_o), 32'd0);
    check("rst_frame_start", 32'(frame_start_o), 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_overflow", 32'(overflow_o), 32'd0);
    check("rst_byte", 32'(byte_o), 32'd0);
    rst_i = 1'b0;
    tick();

    // Basic word, latency
    push_word(24'h5A1234);
    capture(24'h5A1234);
    check("lat_k_valid", 32'(byte_valid_o), 32'd0);
    check("lat_k_count", 32'(count_o), 32'd1);
    tick();
    check("lat_k1_valid", 32'(byte_valid_o), 32'd1);
    check("lat_k1_frame_start", 32'(frame_start_o), 32'd1);
    check("lat_k1_byte", 32'(byte_o), 32'h34);
    tick(); tick(); tick();
    check("basic_end_valid", 32'(byte_valid_o), 32'd0);
    check("basic_end_count", 32'(count_o), 32'd0);

    // Stall during byte1
    push_word(24'h5A1234);
    capture(24'h5A1234);
    tick();
    tick();
    byte_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_byte", 32'(byte_o), 32'h12);
      check("stall_valid", 32'(byte_valid_o), 32'd1);
      check("stall_frame_start", 32'(frame_start_o), 32'd0);
      tick();
    end
    check("stall_end_byte", 32'(byte_o), 32'h12);
    byte_ready_i = 1'b1;
    tick();
    check("stall_resume_byte", 32'(byte_o), 32'h5A);
    tick();
    check("stall_done_valid", 32'(byte_valid_o), 32'd0);

    // Overflow: 5 captures, ready low
    words[0] = 24'h112233; words[1] = 24'h445566; words[2] = 24'h778899;
    words[3] = 24'h0ABCDE; words[4] = 24'h7FFFFF;
    byte_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) push_word(words[i]);
      capture(words[i]);
    end
    check("ovf_count", 32'(count_o), 32'd4);
    check("ovf_flag", 32'(overflow_o), 32'd1);
    byte_ready_i = 1'b1;
    wait_drain("ovf");
    check("ovf_drain_count", 32'(count_o), 32'd0);
    check("ovf_sticky", 32'(overflow_o), 32'd1);
    clear_ovf_i = 1'b1;
    tick();
    clear_ovf_i = 1'b0;
    check("ovf_cleared", 32'(overflow_o), 32'd0);

    // Full FIFO, capture coincides with byte2 handshake
    words[0] = 24'h010203; words[1] = 24'h040506; words[2] = 24'h070809;
    words[3] = 24'h0A0B0C; words[4] = 24'h3C2D1E;
    byte_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_word(words[i]);
      capture(words[i]);
    end
    check("simul_full_count", 32'(count_o), 32'd4);
    byte_ready_i = 1'b1;
    tick();
    tick();
    push_word(words[4]);
    capture(words[4]);
    check("simul_count", 32'(count_o), 32'd4);
    check("simul_overflow", 32'(overflow_o), 32'd0);
    wait_drain("simul");
    check("simul_drain_count", 32'(count_o), 32'd0);

    // Capture ignored while en_i low
    byte_ready_i = 1'b0;
    push_word(24'h000042);
    capture(24'h000042);
    check("en_pre_count", 32'(count_o), 32'd1);
    en_i = 1'b0;
    capture(24'h000007);
    en_i = 1'b1;
    check("en_count", 32'(count_o), 32'd1);
    check("en_overflow", 32'(overflow_o), 32'd0);
    byte_ready_i = 1'b1;
    wait_drain("en");

    // Reset mid-frame with words queued; capture during reset discarded
    byte_ready_i = 1'b0;
    capture(24'h7FFFFF);
    capture(24'h0AAAAA);
    capture(24'h055555);
    exp_q.push_back({1'b1, 8'hFF});
    byte_ready_i = 1'b1;
    tick();
    byte_ready_i = 1'b0;
    check("mid_byte1", 32'(byte_o), 32'hFF);
    check("mid_count", 32'(count_o), 32'd3);
    rst_i = 1'b1;
    capture(24'h123456);
    rst_i = 1'b0;
    check("mid_rst_valid", 32'(byte_valid_o), 32'd0);
    check("mid_rst_count", 32'(count_o), 32'd0);
    check("mid_rst_byte", 32'(byte_o), 32'd0);
    check("mid_rst_frame_start", 32'(frame_start_o), 32'd0);
    byte_ready_i = 1'b1;
    repeat (4) tick();
    check("mid_no_resume", 32'(byte_valid_o), 32'd0);
    push_word(24'h000001);
    capture(24'h000001);
    wait_drain("post_rst");
    check("post_rst_idle", 32'(byte_valid_o), 32'd0);

    // Back-to-back streaming, no idle cycle
    push_word(24'h6E5D4C);
    capture(24'h6E5D4C);
    push_word(24'h123ABC);
    capture(24'h123ABC);
    push_word(24'h00FF00);
    capture(24'h00FF00);
    for (int i = 0; i < 8; i++) begin
      check("stream_valid", 32'(byte_valid_o), 32'd1);
      tick();
    end
    check("stream_end_valid", 32'(byte_valid_o), 32'd0);
    check("stream_all_bytes", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/result_serializer.md
RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 23, giving the width of the output-neuron result word.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of result words buffered (power of two).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port en_i, input, 1 bit: capture enable.
REQ-006 The block SHALL have port capture_i, input, 1 bit: one-cycle pulse meaning the forward pass is over and final_i is valid.
REQ-007 The block SHALL have port final_i, input, DATA_W bits: the output-neuron result word.
REQ-008 The block SHALL have port byte_o, output, 8 bits: the current serialized byte.
REQ-009 The block SHALL have port byte_valid_o, output, 1 bit: byte_o is valid.
REQ-010 The block SHALL have port byte_ready_i, input, 1 bit: the consumer accepts byte_o.
REQ-011 The block SHALL have port frame_start_o, output, 1 bit: high while byte_o is byte 0 of a word.
REQ-012 The block SHALL have port count_o, output, clog2(DEPTH)+1 bits: FIFO occupancy in words.
REQ-013 The block SHALL have port overflow_o, output, 1 bit: sticky flag, set when a capture is dropped.
REQ-014 The block SHALL have port clear_ovf_i, input, 1 bit: clears overflow_o.

Function
REQ-015 A write SHALL occur when capture_i & en_i & (not full, or a final-byte handshake occurs in the same cycle); the write stores final_i at the tail.
REQ-016 capture_i SHALL be ignored while en_i=0, without setting overflow.
REQ-017 On capture_i & en_i when full with no same-cycle pop, the word SHALL be dropped and overflow_o set at the next edge.
REQ-018 Each word SHALL be sent as 3 bytes in this order: byte0=final[7:0], byte1=final[15:8], byte2={0,final[22:16]} (upper bits zero-padded).
REQ-019 The byte-index state machine SHALL have states IDLE, SEND0, SEND1 and SEND2.
REQ-020 State transitions: IDLE->SEND0 when not empty; SENDn->SEND(n+1) on handshake (byte_valid_o & byte_ready_i); SEND2 on handshake pops the head and goes to SEND0 if count after pop >0, else IDLE.
REQ-021 byte_valid_o SHALL be 1 exactly in the SEND states; frame_start_o SHALL be 1 exactly in SEND0.
REQ-022 Latency: a capture into an empty FIFO at edge k SHALL give byte_valid_o=1 with byte0 from edge k+1 (state updated at edge k).
REQ-023 While byte_valid_o=1 and byte_ready_i=0, byte_o and frame_start_o SHALL remain stable.
REQ-024 Back-to-back words SHALL stream with no idle cycle when byte_ready_i stays 1 (3 bytes per 3 cycles).
REQ-025 A simultaneous write and pop SHALL leave count_o unchanged; pointers SHALL wrap modulo DEPTH.
REQ-026 A write into an empty FIFO SHALL never be visible as a pop in the same cycle.
REQ-027 clear_ovf_i SHALL clear overflow_o at the next edge; if clear_ovf_i and a new drop coincide, the set wins.

Reset
REQ-028 On rst_i=1 at an edge, the block SHALL clear both pointers and count_o, set state to IDLE, and clear byte_valid_o, frame_start_o and overflow_o; byte_o SHALL be 0.
REQ-029 A reset mid-frame SHALL discard the partial word and all buffered words, with no resumption afterwards.
REQ-030 Captures in the same cycle as rst_i=1 SHALL be discarded.

Structure
REQ-031 Shared package result_pkg SHALL hold DATA_W, DEPTH, BYTES_PER_WORD=3 and the state enum.
REQ-032 Storage SHALL be one sub-module, result_fifo: a synchronous FIFO with write, pop, head, count, full and empty.
REQ-033 The serializer state machine and the overflow logic SHALL live in result_serializer.

Verification
REQ-034 Bench: reset, capture final_i=0x5A1234 with ready=1 -> byte_o sequence 0x34 (frame_start=1), 0x12, 0x5A over edges k+1..k+3, then byte_valid_o=0.
REQ-035 Bench: ready held 0 for 5 cycles during byte1 -> byte_o=0x12 stable; it proceeds on the first ready=1 cycle.
REQ-036 Bench: 5 captures with ready=0 -> count_o=4, overflow_o=1; drain yields the first 4 words in order; clear_ovf_i -> overflow_o=0.
REQ-037 Bench: FIFO full, capture coincides with the byte2 handshake -> word accepted, count_o stays 4, overflow_o=0.
REQ-038 Bench: rst_i asserted during byte1 of 0x7FFFFF with 2 words queued -> next cycle byte_valid_o=0, count_o=0; a new capture 0x000001 emits 0x01, 0x00, 0x00.
REQ-039 Bench: capture_i with en_i=0 -> count_o unchanged, overflow_o=0.
